servo_val_limiter: RTL

SERVO_VAL_LIMITER -- requirements
Module: servo_val_limiter

---
 rtl/servo_val_limiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/servo_val_limiter.sv
// -----------------------------------------------------------------------------
// servo_val_limiter
//
// Purpose:
//   Two-stage pipeline that turns raw servo position requests into slew-limited
//   channel values. Stage 1 applies a per-transaction transform (offset,
//   clamp, compress or bypass) and clamps the result to [MIN, MAX] unless the
//   transform is bypass. Stage 2 limits the change of the addressed channel to
//   STEP per update and writes the result into the channel store.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-low
//   in_valid   in   one-cycle request strobe
//   in_ch      in   target channel (requests with in_ch >= CH are dropped)
//   in_mode    in   transform: 00 offset, 01 clamp, 10 compress, 11 bypass
//   in_val     in   unsigned raw position
//   out_valid  out  one-cycle strobe, two cycles after the accepted request
//   out_ch     out  channel of the update (holds while out_valid is low)
//   out_val    out  new channel value (holds while out_valid is low)
//   y_val_lim  out  all channel values, channel k at [k*W +: W]
// -----------------------------------------------------------------------------
module servo_val_limiter #(
    parameter int W      = 11,
    parameter int CH     = 2,
    parameter int MIN    = 500,
    parameter int MAX    = 1500,
    parameter int CENTER = 1000,
    parameter int OFFSET = 300,
    parameter int STEP   = 100,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [CW-1:0]   in_ch,
    input  logic [1:0]      in_mode,
    input  logic [W-1:0]    in_val,
    output logic            out_valid,
    output logic [CW-1:0]   out_ch,
    output logic [W-1:0]    out_val,
    output logic [CH*W-1:0] y_val_lim
);

    // Signed working width: two extra bits keep in_val - CENTER and
    // in_val - OFFSET representable without wrap.
    localparam int SW    = W + 2;
    localparam int NSLOT = 1 << CW;

    localparam logic signed [SW-1:0] ZERO_S  = {SW{1'b0}};
    localparam logic signed [SW-1:0] MIN_S   = SW'(MIN);
    localparam logic signed [SW-1:0] MAX_S   = SW'(MAX);
    localparam logic signed [SW-1:0] CEN_S   = SW'(CENTER);
    localparam logic signed [SW-1:0] OFF_S   = SW'(OFFSET);
    localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
    localparam logic signed [SW-1:0] NSTEP_S = ZERO_S - STEP_S;
    localparam logic [W-1:0]         CEN_W   = W'(CENTER);
    localparam logic                 SLEW_EN = (STEP != 0) ? 1'b1 : 1'b0;

    // Clamp a signed working value into [MIN, MAX].
    function automatic logic signed [SW-1:0] clamp_rng(input logic signed [SW-1:0] v);
        if (v < MIN_S) begin
            return MIN_S;
        end else if (v > MAX_S) begin
            return MAX_S;
        end else begin
            return v;
        end
    endfunction

    // Per-index legality table; lets a non-power-of-two CH reject the unused
    // encodings of in_ch without a constant-folded compare.
    logic [NSLOT-1:0] ch_ok_s;
    for (genvar k = 0; k < NSLOT; k++) begin : g_ch_ok
        assign ch_ok_s[k] = (k < CH) ? 1'b1 : 1'b0;
    end

    // Stage 1 registers
    logic          s1_valid_q, s1_valid_d;
    logic [CW-1:0] s1_ch_q;
    logic [W-1:0]  s1_tgt_q, s1_tgt_d;

    // Stage 2 / output registers
    logic            out_valid_q;
    logic [CW-1:0]   out_ch_q;
    logic [W-1:0]    out_val_q, out_val_d;
    logic [CH*W-1:0] y_q;

    logic signed [SW-1:0] in_s, off_s, half_s, tgt_s;
    logic signed [SW-1:0] prev_s, tgt2_s, diff_s, new_s;

    // Stage 1 target: transform selected by in_mode, then range clamp.
    always_comb begin
        in_s  = $signed({2'b00, in_val});
        off_s = in_s - OFF_S;
        if (off_s < ZERO_S) begin
            off_s = ZERO_S;
        end else begin
            off_s = in_s - OFF_S;
        end
        // Arithmetic shift gives floor division for negative distances.
        half_s = (in_s - CEN_S) >>> 1;
        tgt_s  = in_s;
        case (in_mode)
            2'b00:   tgt_s = clamp_rng(off_s);
            2'b01:   tgt_s = clamp_rng(in_s);
            2'b10:   tgt_s = clamp_rng(CEN_S + half_s);
            2'b11:   tgt_s = in_s;
            default: tgt_s = in_s;
        endcase
        s1_tgt_d   = tgt_s[W-1:0];
        s1_valid_d = in_valid & ch_ok_s[in_ch];
    end

    // Stage 1 pipeline register; illegal channels never become valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= {CW{1'b0}};
            s1_tgt_q   <= {W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_valid) begin
                s1_ch_q  <= in_ch;
                s1_tgt_q <= s1_tgt_d;
            end
        end
    end

    // Stage 2 slew limit. The channel store is written in this same stage, so
    // a back-to-back update of one channel already reads the freshly written
    // value: forwarding falls out of the structure.
    always_comb begin
        prev_s = $signed({2'b00, y_q[s1_ch_q*W +: W]});
        tgt2_s = $signed({2'b00, s1_tgt_q});
        diff_s = tgt2_s - prev_s;
        new_s  = tgt2_s;
        if (SLEW_EN && (diff_s > STEP_S)) begin
            new_s = prev_s + STEP_S;
        end else if (SLEW_EN && (diff_s < NSTEP_S)) begin
            new_s = prev_s - STEP_S;
        end else begin
            new_s = tgt2_s;
        end
        out_val_d = new_s[W-1:0];
    end

    // Stage 2 register: output strobe, held out_ch/out_val, channel store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= {CW{1'b0}};
            out_val_q   <= {W{1'b0}};
            y_q         <= {CH{CEN_W}};
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_ch_q               <= s1_ch_q;
                out_val_q              <= out_val_d;
                y_q[s1_ch_q*W +: W]    <= out_val_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_val   = out_val_q;
    assign y_val_lim = y_q;

endmodule
